// File: rtl/stream_demux_1to4.sv
// stream_demux_1to4: routes a packetised input stream to one of four output
// channels. The channel is picked by in_sel on the first word of a packet and
// held for the rest of the packet. Each channel has a single-entry output slot.

// One output slot: a word register plus its valid flag. A load wins over a
// drain in the same cycle, so back-to-back words pass through without a bubble.
module stream_demux_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             valid
);

  // Slot register: reset clears everything, load overwrites, drain empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= ld_data;
      last  <= ld_last;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

module stream_demux_1to4 #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_last,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic                 busy,
  output logic [1:0]           active_ch,
  output logic [7:0]           pkt_count
);

  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [1:0]     locked_ch;
  logic [1:0]     target;
  logic           accept;
  logic [NUM_LANES-1:0] load;

  // Destination follows in_sel between packets and the latched channel inside one.
  assign target    = (state == BURST) ? locked_ch : in_sel;
  assign active_ch = target;
  assign busy      = (state == BURST);

  // A word can go in if the target slot is empty or is being emptied this cycle.
  assign in_ready  = !out_valid[target] || out_ready[target];
  assign accept    = in_valid && in_ready;

  // Per-channel slots; only the target slot ever sees a load.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign load[k] = accept && (target == 2'(k));

    stream_demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (load[k]),
      .ld_data (in_data),
      .ld_last (in_last),
      .ready   (out_ready[k]),
      .data    (out_data[k*WIDTH +: WIDTH]),
      .last    (out_last[k]),
      .valid   (out_valid[k])
    );
  end

  // Packet framing: a non-last first word opens a burst, a last word closes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !in_last) state_nxt = BURST;
      BURST:   if (accept &&  in_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, locked channel and packet counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      locked_ch <= 2'd0;
      pkt_count <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept && !in_last) locked_ch <= in_sel;
      if (accept && in_last) pkt_count <= pkt_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Directed bench for stream_demux_1to4: single-word and multi-word packets,
// backpressure, independent channel drain, mid-burst reset and counter wrap.
module tb_stream_demux_1to4;

  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_last;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_last;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic               busy;
  logic [1:0]         active_ch;
  logic [7:0]         pkt_count;

  int tests = 0;
  int fails = 0;

  stream_demux_1to4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .active_ch (active_ch),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic l, input logic [15:0] d);
    in_valid = v;
    in_sel   = s;
    in_last  = l;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    out_ready = 4'b1111;
    tick(); tick();
    chk("rst_valid", out_valid, 4'b0000);
    chk("rst_last",  out_last,  4'b0000);
    chk("rst_data",  out_data,  64'h0);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_pkt",   pkt_count, 8'd0);
    rst = 1'b0;
    tick();

    // single-word packet to channel 2
    drive(1'b1, 2'd2, 1'b1, 16'hA5A5);
    #1;
    chk("sw_ready",  in_ready,  1'b1);
    chk("sw_active", active_ch, 2'd2);
    tick();
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    chk("sw_valid", out_valid, 4'b0100);
    chk("sw_data",  out_data[47:32], 16'hA5A5);
    chk("sw_last",  out_last,  4'b0100);
    chk("sw_pkt",   pkt_count, 8'd1);
    chk("sw_busy",  busy,      1'b0);
    tick();
    chk("sw_drain", out_valid, 4'b0000);

    // 3-word packet locked to channel 1 while in_sel changes
    drive(1'b1, 2'd1, 1'b0, 16'h1111);
    tick();
    chk("b1_busy",  busy,      1'b1);
    chk("b1_valid", out_valid, 4'b0010);
    chk("b1_data",  out_data[31:16], 16'h1111);
    drive(1'b0, 2'd3, 1'b0, 16'h0);
    tick();
    chk("bgap_busy",   busy,      1'b1);
    chk("bgap_active", active_ch, 2'd1);
    drive(1'b1, 2'd3, 1'b0, 16'h2222);
    #1;
    chk("b2_active", active_ch, 2'd1);
    tick();
    chk("b2_valid", out_valid, 4'b0010);
    chk("b2_data",  out_data[31:16], 16'h2222);
    chk("b2_busy",  busy,      1'b1);
    drive(1'b1, 2'd3, 1'b1, 16'h3333);
    tick();
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    chk("b3_valid", out_valid, 4'b0010);
    chk("b3_data",  out_data[31:16], 16'h3333);
    chk("b3_last",  out_last[1], 1'b1);
    chk("b3_busy",  busy,      1'b0);
    chk("b3_pkt",   pkt_count, 8'd2);
    tick();
    chk("b3_drain", out_valid, 4'b0000);

    // backpressure on channel 0, two back-to-back words
    out_ready = 4'b1110;
    drive(1'b1, 2'd0, 1'b1, 16'h0A0A);
    tick();
    chk("bp_a_valid", out_valid, 4'b0001);
    chk("bp_a_data",  out_data[15:0], 16'h0A0A);
    drive(1'b1, 2'd0, 1'b1, 16'h0B0B);
    #1;
    chk("bp_stall_ready", in_ready, 1'b0);
    tick();
    chk("bp_hold_data", out_data[15:0], 16'h0A0A);
    chk("bp_hold_valid", out_valid, 4'b0001);
    chk("bp_hold_pkt",  pkt_count, 8'd3);
    out_ready = 4'b1111;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    tick();
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    chk("bp_b_valid", out_valid, 4'b0001);
    chk("bp_b_data",  out_data[15:0], 16'h0B0B);
    chk("bp_b_pkt",   pkt_count, 8'd4);
    tick();
    chk("bp_drain", out_valid, 4'b0000);

    // channel 1 stalled, channel 3 still accepts
    out_ready = 4'b1101;
    drive(1'b1, 2'd1, 1'b1, 16'hC1C1);
    tick();
    chk("ind_c1_valid", out_valid, 4'b0010);
    drive(1'b1, 2'd3, 1'b1, 16'hD3D3);
    #1;
    chk("ind_c3_ready", in_ready, 1'b1);
    tick();
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    chk("ind_both_valid", out_valid, 4'b1010);
    chk("ind_c3_data", out_data[63:48], 16'hD3D3);
    chk("ind_c1_data", out_data[31:16], 16'hC1C1);
    chk("ind_pkt", pkt_count, 8'd6);
    tick();
    chk("ind_c3_drain", out_valid, 4'b0010);
    chk("ind_c1_keep",  out_data[31:16], 16'hC1C1);
    out_ready = 4'b1111;
    tick();
    chk("ind_c1_drain", out_valid, 4'b0000);

    // reset in the middle of a 4-word burst, with a word offered the same cycle
    drive(1'b1, 2'd2, 1'b0, 16'h0001);
    tick();
    drive(1'b1, 2'd2, 1'b0, 16'h0002);
    tick();
    chk("mr_busy_pre", busy, 1'b1);
    rst = 1'b1;
    drive(1'b1, 2'd2, 1'b0, 16'h0003);
    tick();
    rst = 1'b0;
    chk("mr_valid", out_valid, 4'b0000);
    chk("mr_busy",  busy,      1'b0);
    chk("mr_pkt",   pkt_count, 8'd0);
    chk("mr_data",  out_data,  64'h0);
    drive(1'b1, 2'd0, 1'b1, 16'h5555);
    #1;
    chk("mr_active", active_ch, 2'd0);
    tick();
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    chk("mr_post_valid", out_valid, 4'b0001);
    chk("mr_post_data",  out_data[15:0], 16'h5555);
    chk("mr_post_pkt",   pkt_count, 8'd1);
    chk("mr_post_busy",  busy, 1'b0);

    // counter wrap: 255 more single-word packets take it from 1 back to 0
    for (int i = 0; i < 254; i++) begin
      drive(1'b1, 2'(i), 1'b1, 16'(i));
      tick();
    end
    chk("wrap_255", pkt_count, 8'd255);
    drive(1'b1, 2'd1, 1'b1, 16'hFFFF);
    tick();
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    chk("wrap_0", pkt_count, 8'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
